// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for serial_subtractor.
// The overflow signal exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             bit_diff;
  logic             bit_valid;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, bit_diff, bit_valid, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, bit_diff, bit_valid, overflow
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, bit_diff, bit_valid
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, bit_diff, bit_valid
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one full-subtractor cell.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow flag.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CNT_W-1:0] cnt;
  logic             br;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             bit_q;
  logic             bit_valid_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb;
  logic             b_msb;
  logic             ov_q;
`endif

  logic ai;
  logic bi;
  logic d;
  logic br_next;
  logic accept;
  logic last;

  // Full-subtractor cell on the current operand LSBs.
  always_comb begin
    ai      = a_sr[0];
    bi      = b_sr[0];
    d       = ai ^ bi ^ br;
    br_next = (~ai & bi) | (~(ai ^ bi) & br);
    accept  = bus.start && (state_q != RUN);
    last    = (state_q == RUN) && (cnt == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.busy       = (state_q == RUN);
    bus.done       = (state_q == DONE);
    bus.diff       = diff_q;
    bus.borrow_out = borrow_q;
    bus.bit_diff   = bit_q;
    bus.bit_valid  = bit_valid_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    bus.overflow   = ov_q;
`endif
  end

  // Operand shift registers, borrow flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      br     <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
`endif
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      res_sr <= '0;
      cnt    <= '0;
      br     <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb  <= bus.a[WIDTH-1];
      b_msb  <= bus.b[WIDTH-1];
`endif
    end else if (state_q == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {d, res_sr[WIDTH-1:1]};
      cnt    <= last ? '0 : cnt + 1'b1;
      br     <= br_next;
    end
  end

  // Serial bit stream and result registers; the result is assembled from the
  // shift register plus the bit being produced on the completion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ov_q        <= 1'b0;
`endif
    end else begin
      bit_valid_q <= 1'b0;
      if (state_q == RUN) begin
        bit_q       <= d;
        bit_valid_q <= 1'b1;
      end
      if (last) begin
        diff_q   <= {d, res_sr[WIDTH-1:1]};
        borrow_q <= br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ov_q     <= (a_msb != b_msb) && (d != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed cases plus randomized operands,
// checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } res_t;

  res_t         resq[$];
  logic         bitq[$];
  logic [W-1:0] held;

  int n_vec = 0;
  int n_err = 0;
  int n_chk = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: plain integer arithmetic modulo 2^W.
  function automatic void push_expected(logic [W-1:0] a, logic [W-1:0] b);
    res_t r;
    int   ua, ub, sa, sb, sd;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sd = sa - sb;
    r.d  = W'(ua - ub);
    r.br = (ua < ub);
    r.ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    resq.push_back(r);
    for (int i = 0; i < W; i++) bitq.push_back(r.d[i]);
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] one;
    one = 1;
    case ($urandom_range(0, 5))
      0:       pick = '0;
      1:       pick = '1;
      2:       pick = one << (W - 1);
      3:       pick = ~(one << (W - 1));
      default: pick = W'($urandom);
    endcase
  endfunction

  // Monitor: pops expectations whenever the DUT presents a bit or a result.
  always @(negedge clk) begin
    res_t r;
    logic e;
    if (!rst_n) begin
      held = '0;
    end else begin
      if (bus.bit_valid) begin
        if (bitq.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL bit_unexpected: got bit_valid=1, expected 0 (t=%0t)", $time);
        end else begin
          e = bitq.pop_front();
          check("bit_diff", 32'(bus.bit_diff), 32'(e));
        end
      end
      if (bus.done) begin
        if (resq.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL done_unexpected: got done=1, expected 0 (t=%0t)", $time);
        end else begin
          r = resq.pop_front();
          check("diff", 32'(bus.diff), 32'(r.d));
          check("borrow_out", 32'(bus.borrow_out), 32'(r.br));
`ifdef SERIAL_SUB_OVERFLOW_EN
          check("overflow", 32'(bus.overflow), 32'(r.ov));
`endif
          held = r.d;
        end
      end else begin
        check("diff_hold", 32'(bus.diff), 32'(held));
      end
    end
  end

  // Drive a start at the current negedge; returns just after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    push_expected(a, b);
    n_vec++;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  // mode 1: extra start mid-RUN; mode 2: start on the completion edge.
  task automatic wait_done(input int mode);
    int n;
    n = 0;
    @(negedge clk);
    check("busy_run", 32'(bus.busy), 32'd1);
    while (!bus.done && n < 4 * W) begin
      if (mode == 1 && n == 1) begin
        bus.start = 1'b1;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
      end
      if (mode == 1 && n == 2) bus.start = 1'b0;
      if (mode == 2 && n == W - 1) bus.start = 1'b1;
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check("done_latency", 32'(n), 32'(W));
  endtask

  task automatic gap();
    @(negedge clk);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("done_idle", 32'(bus.done), 32'd0);
    check("bit_valid_idle", 32'(bus.bit_valid), 32'd0);
  endtask

  task automatic back_to_back(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
    check("busy_in_done", 32'(bus.busy), 32'd0);
    issue(a, b);
    wait_done(mode);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_bit_valid"}, 32'(bus.bit_valid), 32'd0);
    check({tag, "_bit_diff"}, 32'(bus.bit_diff), 32'd0);
    check({tag, "_diff"}, 32'(bus.diff), 32'd0);
    check({tag, "_borrow_out"}, 32'(bus.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    int mode;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Case 1..3
    issue(8'd200, 8'd55);  wait_done(0); gap();
    issue(8'd5, 8'd10);    wait_done(0); gap();
    issue(8'hA5, 8'hA5);   wait_done(0); gap();

    // Case 4: back-to-back through the DONE cycle
    issue(8'd9, 8'd3); wait_done(0);
    back_to_back(8'd3, 8'd9, 0);
    gap();

    // Case 5: ignored mid-RUN start, then reset on the 4th RUN cycle
    issue(8'h3C, 8'h11);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bitq.delete();
    resq.delete();
    #1;
    check_all_zero("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("no_activity_after_reset", 32'(seen), 32'd0);
    issue(8'd1, 8'd1); wait_done(0); gap();

    // Case 6: signed overflow boundaries
    issue(8'h80, 8'h01); wait_done(0); gap();
    issue(8'h10, 8'h01); wait_done(0); gap();

    // Start on the completion edge is ignored
    issue(8'h42, 8'h24); wait_done(2); gap();

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      mode = $urandom_range(0, 2);
      issue(pick(), pick());
      wait_done(mode);
      if ($urandom_range(0, 1) == 1 && mode != 2) begin
        back_to_back(pick(), pick(), int'($urandom_range(0, 1)));
      end
      gap();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(resq.size() + bitq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart to the team's adder cells. It sits beside the serial adder in the arithmetic datapath and trades latency for area. A start/done handshake wraps the computation, and each difference bit is also streamed out as it is produced.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range is 2 or more.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new subtraction; sampled on the rising edge.
- `a`  in  WIDTH  minuend; captured only on an accepted start.
- `b`  in  WIDTH  subtrahend; captured only on an accepted start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the result is valid.
- `diff`  out  WIDTH  result register; holds its value until the next completion.
- `borrow_out`  out  1  final borrow, meaning unsigned `a < b`; updated with `diff`.
- `bit_diff`  out  1  serial difference bit for the current RUN step.
- `bit_valid`  out  1  qualifies `bit_diff`; high for exactly WIDTH cycles per operation.
- `overflow`  out  1  signed overflow flag; present only with `SERIAL_SUB_OVERFLOW_EN`.

## Operation
- States:
  - IDLE: reset state.
  - RUN: bit processing.
  - DONE: one cycle, then IDLE.
- Accepting a start:
  - A start is accepted when `start=1` in IDLE or DONE.
  - On acceptance, load the `a`/`b` shift registers, clear the bit counter and the borrow flop, and enter RUN.
  - `start` in RUN is ignored. Operands are not re-sampled.
- Each RUN edge, with `ai`/`bi` the current LSBs and `br` the borrow flop:
  - `d = ai ^ bi ^ br`.
  - `br_next = (~ai & bi) | (~(ai ^ bi) & br)`.
  - Shift `d` into the MSB of the internal result shift register, and shift the operands right.
  - Register `d` to `bit_diff` and set `bit_valid=1`.
  - Increment the counter. The counter wraps at WIDTH-1, and `$clog2(WIDTH)` bits are sufficient.
- Completion, on the RUN edge where the counter equals WIDTH-1:
  - Copy the internal result to `diff`.
  - Set `borrow_out = br_next`.
  - Set `done=1` and go to DONE.
- Width rule: arithmetic is modulo 2^WIDTH. `diff` is never widened, and the borrow is reported only through `borrow_out`.

## Timing
- Reset values, applied asynchronously when `rst_n=0`:
  - State IDLE.
  - `busy`, `done`, `bit_diff`, `bit_valid`, `borrow_out`, `overflow` all 0.
  - `diff` is 0. Shift registers, counter and borrow flop are cleared.
- Latency: with the accepting edge at T0, `busy=1` from T0 to T0+WIDTH. `done=1` for the single cycle following edge T0+WIDTH.
- `bit_valid`/`bit_diff`:
  - Bit i (LSB = bit 0) is visible in the cycle after edge T0+1+i.
  - The last bit (i = WIDTH-1) is visible in the same cycle as `done`.
  - `bit_valid` drops the cycle after that.
- Back-to-back: `start=1` during the DONE cycle is accepted on that edge. `busy` stays low for exactly one cycle (the DONE cycle), giving a throughput of one result per WIDTH+1 cycles.
- Reset mid-RUN: the operation is abandoned and no `done` is produced. `diff`/`borrow_out` return to 0.
- Simultaneous `start` and completion edge: this edge is in RUN, so `start` is ignored.

## Configuration
- Macro: `SERIAL_SUB_OVERFLOW_EN`.
- Defined:
  - The `overflow` port exists.
  - At the completion edge, register `overflow = (a_msb != b_msb) & (d_msb != a_msb)`, where `a_msb`/`b_msb` are captured at acceptance.
  - It holds with `diff` and is cleared by reset.
- Undefined: the `overflow` port and its logic are absent. All other behaviour is identical.

## Test plan
- Case 1: WIDTH=8, a=200, b=55, start pulse. Required: `done` 8 cycles later, `diff`=145, `borrow_out`=0, serial bits LSB-first 1,0,0,0,1,0,0,1.
- Case 2: a=5, b=10. Required: `diff`=251 (0xFB), `borrow_out`=1.
- Case 3: a=b=0xA5. Required: `diff`=0, `borrow_out`=0, `bit_diff`=0 on all 8 `bit_valid` cycles.
- Case 4: start for 9-3, then reassert start in the DONE cycle with 3-9. Required: second result `diff`=250 with `borrow_out`=1; first `diff`=6 held until then; `busy` low for exactly one cycle.
- Case 5: assert start again during RUN, then pull `rst_n` low at the 4th RUN cycle. Required: the mid-RUN start has no effect; after reset no `done`, all outputs 0, and a fresh start for 1-1 completes normally with `diff`=0.
- Case 6: with `SERIAL_SUB_OVERFLOW_EN`, compute 0x80-0x01 and 0x10-0x01. Required: `diff`=0x7F with `overflow`=1, and `diff`=0x0F with `overflow`=0.
